// File: rtl/uart_tx_fifo.sv
// Buffered UART transmit front-end: byte FIFO drained through the uart sendData/sendReq/ready handshake.
// Optional registered low-watermark interrupt output tx_irq when UART_TXF_IRQ_EN is defined.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  input  logic        clr_overflow,
  output logic [31:0] status,
  output logic [7:0]  uart_data,
  output logic        uart_send,
  input  logic        uart_ready,
`ifdef UART_TXF_IRQ_EN
  output logic        tx_irq,
`endif
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    uart_data_q, uart_data_d;
  logic          uart_send_q, uart_send_d;
  logic          full, empty, push, drop, pop;

  // Handshake: a byte is handed to the transmitter by a one-cycle uart_send pulse
  // with uart_data valid, only when uart_ready was high in IDLE; GUARD then skips
  // one cycle because the transmitter drops ready one cycle late.
  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    push  = wr_valid && !full;
    drop  = wr_valid && full;
    pop   = (state_q == IDLE) && !empty && uart_ready;

    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = GUARD;
      GUARD:   state_d = WAIT;
      WAIT:    if (uart_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    uart_send_d = pop;
    uart_data_d = pop ? mem_q[rd_ptr_q] : uart_data_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    // A dropped push in the same cycle as a clear leaves the flag set.
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      uart_data_q <= 8'h00;
      uart_send_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      uart_data_q <= uart_data_d;
      uart_send_q <= uart_send_d;
    end
  end

  always_comb begin
    status       = '0;
    status[0]    = !full;
    status[1]    = empty && (state_q == IDLE) && uart_ready && !reset;
    status[2]    = overflow_q;
    status[15:8] = 8'(count_q);
  end

  assign uart_data = uart_data_q;
  assign uart_send = uart_send_q;
  assign dbg_state = state_q;

`ifdef UART_TXF_IRQ_EN
  localparam logic [CW-1:0] IRQ_CNT = CW'(DEPTH / 4);

  logic tx_irq_q, tx_irq_d;
  logic armed_q, armed_d;

  // armed remembers that the FIFO held data since the interrupt last fired.
  always_comb begin
    armed_d = armed_q;
    if (tx_irq_q) armed_d = 1'b0;
    if (!empty)   armed_d = 1'b1;

    if (tx_irq_q) tx_irq_d = !wr_valid;
    else          tx_irq_d = (armed_q || !empty) && (count_q <= IRQ_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_irq_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      tx_irq_q <= tx_irq_d;
      armed_q  <= armed_d;
    end
  end

  assign tx_irq = tx_irq_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed plus randomized bench for uart_tx_fifo against a queue-based reference model
// with a simple transmitter model that drops ready one cycle after each send.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset, wr_valid, clr_overflow, uart_ready, uart_send;
  logic [7:0]  wr_data, uart_data;
  logic [31:0] status;
  logic [1:0]  dbg_state;
`ifdef UART_TXF_IRQ_EN
  logic        tx_irq;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .clr_overflow (clr_overflow),
    .status       (status),
    .uart_data    (uart_data),
    .uart_send    (uart_send),
    .uart_ready   (uart_ready),
`ifdef UART_TXF_IRQ_EN
    .tx_irq       (tx_irq),
`endif
    .dbg_state    (dbg_state)
  );

  logic [7:0] exp_q[$];
  bit         exp_ovf;
  int         n_vec, n_err;
  int         since_send;
  int         frame_len, busy, pushes;
  bit         drop_next, uart_auto;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_vec++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  // One clock: model the inputs seen at the edge, check outputs, then step the transmitter model.
  task automatic tick();
    logic [7:0] sent;
    @(posedge clk);
    #1;
    since_send++;
    if (reset) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      chk("rst_send", 32'(uart_send), 32'd0);
      chk("rst_status", status, 32'h0000_0001);
`ifdef UART_TXF_IRQ_EN
      chk("rst_irq", 32'(tx_irq), 32'd0);
`endif
    end else begin
      if (clr_overflow) exp_ovf = 1'b0;
      if (wr_valid) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(wr_data);
        else exp_ovf = 1'b1;
      end
      if (uart_send) begin
        chk("send_gap", 32'(since_send >= 3), 32'd1);
        chk("send_ready", 32'(uart_ready), 32'd1);
        chk("send_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          sent = exp_q.pop_front();
          chk("send_data", 32'(uart_data), 32'(sent));
        end
        since_send = 0;
      end
      chk("count", 32'(status[15:8]), 32'(exp_q.size()));
      chk("not_full", 32'(status[0]), 32'(exp_q.size() != DEPTH));
      chk("overflow", 32'(status[2]), 32'(exp_ovf));
      if (exp_q.size() != 0) chk("drained_busy", 32'(status[1]), 32'd0);
    end
    if (uart_auto) begin
      if (uart_send) drop_next = 1'b1;
      else if (drop_next) begin
        drop_next  = 1'b0;
        uart_ready = 1'b0;
        busy       = frame_len;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) uart_ready = 1'b1;
      end
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && uart_ready && !drop_next) break;
      tick();
    end
    chk("drain_done", 32'(exp_q.size() == 0 && uart_ready), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0;
    uart_ready = 1'b1; uart_auto = 1'b0; frame_len = 4; busy = 0; drop_next = 1'b0;
    since_send = 100; n_vec = 0; n_err = 0;

    // Reset held two cycles, then idle with the transmitter ready.
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_status", status, 32'h0000_0003);
    chk("post_reset_send", 32'(uart_send), 32'd0);

    // Single byte: two-edge latency, one-cycle pulse, data held afterwards.
    uart_auto = 1'b1;
    wr_valid = 1'b1; wr_data = 8'h41;
    tick();
    wr_valid = 1'b0;
    chk("lat_edge1", 32'(uart_send), 32'd0);
    tick();
    chk("lat_edge2", 32'(uart_send), 32'd1);
    chk("lat_data", 32'(uart_data), 32'h41);
    tick();
    chk("single_pulse", 32'(uart_send), 32'd0);
    drain(100);
    chk("single_status", status, 32'h0000_0003);
    chk("data_hold", 32'(uart_data), 32'h41);

    // Fill to full with the transmitter busy, then exercise the overflow flag.
    uart_auto = 1'b0;
    uart_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("full_status", status, 32'h0000_1000);
    push(8'hAA);
    chk("ovf_set", 32'(status[2]), 32'd1);
    chk("ovf_count", 32'(status[15:8]), 32'd16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clr", 32'(status[2]), 32'd0);
    clr_overflow = 1'b1;
    push(8'hBB);
    clr_overflow = 1'b0;
    chk("ovf_set_wins", 32'(status[2]), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;

    // Drain the burst with 20-cycle frames; order is checked by the model.
    uart_auto = 1'b1; frame_len = 20; busy = 0; drop_next = 1'b0; uart_ready = 1'b1;
    drain(16 * 40);
    chk("burst_status", status, 32'h0000_0003);

    // Randomized pushes interleaved with short frames so the pointers wrap.
    pushes = 0;
    while (pushes < 40) begin
      frame_len = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) begin
        wr_valid = 1'b1;
        wr_data  = 8'($urandom_range(0, 255));
        pushes++;
      end
      clr_overflow = ($urandom_range(0, 15) == 0);
      tick();
      wr_valid = 1'b0;
      clr_overflow = 1'b0;
    end
    drain(2000);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("wrap_status", status, 32'h0000_0003);

    // Reset while waiting on the transmitter with five bytes queued.
    frame_len = 20;
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
    chk("pre_reset_count", 32'(status[15:8]), 32'd5);
    chk("pre_reset_ready", 32'(uart_ready), 32'd0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("no_send_after_reset", 32'(uart_send), 32'd0);
`ifdef UART_TXF_IRQ_EN
      chk("irq_after_reset", 32'(tx_irq), 32'd0);
`endif
    end
    chk("after_reset_status", status, 32'h0000_0003);
    push(8'h5A);
    drain(100);
    chk("final_data", 32'(uart_data), 32'h5A);
    chk("final_status", status, 32'h0000_0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
